// File: rtl/dice_game_pkg.sv
// Shared types and helpers for the dice game: dice face limits, the turn
// arbiter state encoding and the face sequencing function.
package dice_game_pkg;

   localparam logic [2:0] DICE_MIN = 3'd1;
   localparam logic [2:0] DICE_MAX = 3'd6;

   typedef enum logic [1:0] {
      ARB,
      ROLL,
      REPORT,
      OVER
   } dice_state_e;

   // Next dice face in the cyclic sequence 1,2,3,4,5,6,1,...
   function automatic logic [2:0] next_face(input logic [2:0] face);
      return (face >= DICE_MAX) ? DICE_MIN : face + 3'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// pointer, wrapping around, and reports it as one-hot grant plus index.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] pointer,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   logic [IDX_W:0] cand;

   // Scan from pointer upward with wrap; the first requester found wins.
   always_comb begin
      // NOTE: every output gets a value before the loop so no path leaves one unassigned (no latch).
      grant = '0;
      index = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, pointer} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
         if (!any && req[cand[IDX_W-1:0]]) begin
            any   = 1'b1;
            index = cand[IDX_W-1:0];
         end
      end
      if (any) grant[index] = 1'b1;
   end

endmodule

// File: rtl/dice_turn_arbiter.sv
// Turn sequencer for the shared electronic dice: round-robin hands the dice
// to a requesting player, rolls while the button is held, scores the roll on
// release and stops the game at WIN_SCORE.
// Optional build macro DICE_EXTRA_TURN_ON_SIX_EN: a non-winning six keeps the
// round-robin pointer on the same player, giving them the next turn first.
module dice_turn_arbiter
   import dice_game_pkg::*;
#(
   parameter int N_PLAYERS    = 4,
   parameter int SCORE_W      = 8,
   parameter int WIN_SCORE    = 30,
   parameter int MIN_ROLL_CYC = 4,
   parameter int TIMEOUT_CYC  = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         new_game,
   input  logic [N_PLAYERS-1:0]         req,
   output logic [N_PLAYERS-1:0]         grant,
   output logic                         rolling,
   output logic [2:0]                   throw,
   output logic                         result_valid,
   output logic [$clog2(N_PLAYERS)-1:0] result_player,
   input  logic [$clog2(N_PLAYERS)-1:0] rd_sel,
   output logic [SCORE_W-1:0]           rd_score,
   output logic                         game_over,
   output logic [$clog2(N_PLAYERS)-1:0] winner
);

   localparam int IDX_W  = $clog2(N_PLAYERS);
   localparam int HOLD_W = $clog2(TIMEOUT_CYC + 1);

   dice_state_e          state_q, state_d;
   logic [IDX_W-1:0]     pointer_q, pointer_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [N_PLAYERS-1:0] grant_q, grant_d;
   logic [2:0]           throw_q, throw_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [IDX_W-1:0]     winner_q, winner_d;
   logic                 score_we;
   logic                 clear_scores;

   logic [SCORE_W-1:0]   score_q [N_PLAYERS];
   logic [SCORE_W:0]     score_sum;
   logic [SCORE_W-1:0]   score_new;
   logic [IDX_W-1:0]     owner_inc;

   logic [N_PLAYERS-1:0] arb_grant;
   logic [IDX_W-1:0]     arb_index;
   logic                 arb_any;

   rr_arbiter #(
      .N     (N_PLAYERS),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req     (req),
      .pointer (pointer_q),
      .grant   (arb_grant),
      .index   (arb_index),
      .any     (arb_any)
   );

   // Saturating score of the current owner including the held throw.
   assign score_sum = {1'b0, score_q[owner_q]} + (SCORE_W+1)'(throw_q);
   assign score_new = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   assign owner_inc = (owner_q == IDX_W'(N_PLAYERS - 1)) ? '0 : owner_q + IDX_W'(1);

   // State and turn registers; rst clears everything including the winner.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q   <= ARB;
         pointer_q <= '0;
         owner_q   <= '0;
         grant_q   <= '0;
         throw_q   <= '0;
         hold_q    <= '0;
         winner_q  <= '0;
      end else begin
         state_q   <= state_d;
         pointer_q <= pointer_d;
         owner_q   <= owner_d;
         grant_q   <= grant_d;
         throw_q   <= throw_d;
         hold_q    <= hold_d;
         winner_q  <= winner_d;
      end
   end

   // Score bank: cleared on rst or new_game, owner's entry updated in REPORT.
   always_ff @(posedge clk) begin
      // NOTE: scores must read zero after reset/new_game, so this array is real flops with reset, not RAM.
      if (rst || clear_scores) begin
         for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
      end else if (score_we) begin
         score_q[owner_q] <= score_new;
      end
   end

   // Next-state and turn bookkeeping; new_game acts like reset except winner.
   always_comb begin
      state_d      = state_q;
      pointer_d    = pointer_q;
      owner_d      = owner_q;
      grant_d      = grant_q;
      throw_d      = throw_q;
      hold_d       = hold_q;
      winner_d     = winner_q;
      score_we     = 1'b0;
      clear_scores = 1'b0;
      if (new_game) begin
         state_d      = ARB;
         pointer_d    = '0;
         owner_d      = '0;
         grant_d      = '0;
         throw_d      = '0;
         hold_d       = '0;
         clear_scores = 1'b1;
      end else begin
         case (state_q)
            ARB: begin
               if (arb_any) begin
                  grant_d = arb_grant;
                  owner_d = arb_index;
                  throw_d = DICE_MIN;
                  hold_d  = HOLD_W'(1);
                  state_d = ROLL;
               end
            end
            ROLL: begin
               if (hold_q >= HOLD_W'(TIMEOUT_CYC)) begin
                  state_d = REPORT;
               end else if (req[owner_q]) begin
                  throw_d = next_face(throw_q);
                  hold_d  = hold_q + HOLD_W'(1);
               end else if (hold_q >= HOLD_W'(MIN_ROLL_CYC)) begin
                  state_d = REPORT;
               end else begin
                  grant_d   = '0;
                  throw_d   = '0;
                  pointer_d = owner_inc;
                  state_d   = ARB;
               end
            end
            REPORT: begin
               score_we = 1'b1;
               grant_d  = '0;
               throw_d  = '0;
               if (score_new >= SCORE_W'(WIN_SCORE)) begin
                  winner_d = owner_q;
                  state_d  = OVER;
               end else begin
`ifdef DICE_EXTRA_TURN_ON_SIX_EN
                  pointer_d = (throw_q == DICE_MAX) ? owner_q : owner_inc;
`else
                  pointer_d = owner_inc;
`endif
                  state_d = ARB;
               end
            end
            OVER: begin
               state_d = OVER;
            end
            default: begin
               state_d = ARB;
            end
         endcase
      end
   end

   assign grant         = grant_q;
   assign throw         = throw_q;
   assign rolling       = (state_q == ROLL);
   assign result_valid  = (state_q == REPORT);
   assign result_player = owner_q;
   assign game_over     = (state_q == OVER);
   assign winner        = winner_q;
   assign rd_score      = (int'(rd_sel) < N_PLAYERS) ? score_q[rd_sel] : '0;

endmodule

// File: tb/tb_dice_turn_arbiter.sv
// Directed bench for dice_turn_arbiter: 4 players, MIN_ROLL_CYC=4,
// TIMEOUT_CYC=10, WIN_SCORE=30. Expected values are hand-computed.
module tb_dice_turn_arbiter;
   import dice_game_pkg::*;

   logic       clk;
   logic       rst;
   logic       new_game;
   logic [3:0] req;
   logic [3:0] grant;
   logic       rolling;
   logic [2:0] throw;
   logic       result_valid;
   logic [1:0] result_player;
   logic [1:0] rd_sel;
   logic [7:0] rd_score;
   logic       game_over;
   logic [1:0] winner;

   int n_assert = 0;
   int n_fail   = 0;

   dice_turn_arbiter #(
      .N_PLAYERS    (4),
      .SCORE_W      (8),
      .WIN_SCORE    (30),
      .MIN_ROLL_CYC (4),
      .TIMEOUT_CYC  (10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .new_game      (new_game),
      .req           (req),
      .grant         (grant),
      .rolling       (rolling),
      .throw         (throw),
      .result_valid  (result_valid),
      .result_player (result_player),
      .rd_sel        (rd_sel),
      .rd_score      (rd_score),
      .game_over     (game_over),
      .winner        (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete valid turn by player p holding for 'hold' cycles.
   task automatic roll(input int p, input int hold, input int face, input string tag);
      req    = '0;
      req[p] = 1'b1;
      tick();
      check({tag, "_grant"}, grant, 32'(1) << p);
      repeat (hold - 1) tick();
      req = '0;
      tick();
      check({tag, "_valid"}, result_valid, 1);
      check({tag, "_player"}, result_player, p);
      check({tag, "_throw"}, throw, face);
      tick();
   endtask

   initial begin
      int         exp_face [8];
      logic [3:0] exp_extra;

      exp_face = '{2, 3, 4, 5, 6, 1, 2, 3};
`ifdef DICE_EXTRA_TURN_ON_SIX_EN
      exp_extra = 4'b0001;
`else
      exp_extra = 4'b0010;
`endif

      rst      = 1'b1;
      new_game = 1'b0;
      req      = '0;
      rd_sel   = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_grant", grant, 0);
      check("rst_throw", throw, 0);
      check("rst_rolling", rolling, 0);
      check("rst_valid", result_valid, 0);
      check("rst_player", result_player, 0);
      check("rst_over", game_over, 0);
      check("rst_winner", winner, 0);
      check("rst_score", rd_score, 0);

      // Player 0 holds 9 cycles: faces 1..6,1,2,3 then reports 3
      req = 4'b0001;
      check("lat_grant_pre", grant, 0);
      tick();
      check("p0_grant", grant, 4'b0001);
      check("p0_rolling", rolling, 1);
      check("p0_throw_1", throw, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("p0_throw_%0d", i + 2), throw, exp_face[i]);
      end
      req = '0;
      tick();
      check("p0_valid", result_valid, 1);
      check("p0_player", result_player, 0);
      check("p0_throw_rep", throw, 3);
      tick();
      check("p0_valid_gone", result_valid, 0);
      check("p0_grant_gone", grant, 0);
      check("p0_throw_gone", throw, 0);
      rd_sel = 2'd0;
      #1;
      check("p0_score", rd_score, 3);

      // Round-robin: serve player 1, then 1010 from pointer 2 picks player 3
      roll(1, 4, 4, "p1_a");
      req = 4'b1010;
      tick();
      check("rr_grant_p3", grant, 4'b1000);
      repeat (3) tick();
      check("rr_p3_throw", throw, 4);
      req = 4'b0010;
      tick();
      check("rr_p3_valid", result_valid, 1);
      check("rr_p3_player", result_player, 3);
      tick();
      req = 4'b1010;
      tick();
      check("rr_grant_p1", grant, 4'b0010);
      repeat (3) tick();
      req = '0;
      tick();
      check("rr_p1_player", result_player, 1);
      check("rr_p1_throw", throw, 4);
      tick();
      rd_sel = 2'd1;
      #1;
      check("rr_p1_score", rd_score, 8);

      // Short press by player 2: discarded, pointer moves to 3
      req = 4'b0100;
      tick();
      check("short_grant", grant, 4'b0100);
      tick();
      tick();
      req = '0;
      tick();
      check("short_valid", result_valid, 0);
      check("short_grant_gone", grant, 0);
      check("short_throw", throw, 0);
      check("short_rolling", rolling, 0);
      rd_sel = 2'd2;
      #1;
      check("short_score", rd_score, 0);
      req = 4'b1111;
      tick();
      check("short_ptr3", grant, 4'b1000);
      req = '0;
      tick();
      check("short2_grant_gone", grant, 0);

      // Player 0 rolls a six with player 1 also requesting
      req = 4'b0011;
      tick();
      check("six_grant", grant, 4'b0001);
      repeat (5) tick();
      check("six_throw", throw, 6);
      req = 4'b0010;
      tick();
      check("six_valid", result_valid, 1);
      check("six_throw_rep", throw, 6);
      tick();
      req = 4'b0011;
      tick();
      check("six_next_grant", grant, exp_extra);
      req = '0;
      tick();
      rd_sel = 2'd0;
      #1;
      check("six_score", rd_score, 9);

      // Timeout: TIMEOUT_CYC=10, button held past it, reports face 4
      req = 4'b0001;
      tick();
      check("to_grant", grant, 4'b0001);
      repeat (9) tick();
      check("to_rolling", rolling, 1);
      check("to_throw", throw, 4);
      tick();
      check("to_valid", result_valid, 1);
      check("to_throw_rep", throw, 4);
      check("to_player", result_player, 0);
      req = '0;
      tick();
      check("to_valid_gone", result_valid, 0);
      check("to_score", rd_score, 13);

      // new_game mid-roll: roll aborted, scores cleared, no report
      req = 4'b0001;
      tick();
      check("ng_rolling", rolling, 1);
      tick();
      tick();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      req      = '0;
      check("ng_rolling_gone", rolling, 0);
      check("ng_grant", grant, 0);
      check("ng_throw", throw, 0);
      check("ng_valid", result_valid, 0);
      check("ng_score", rd_score, 0);
      tick();
      check("ng_no_report", result_valid, 0);

      // Win: player 1 reaches 28, then rolls 2 for 30
      roll(1, 6, 6, "w1");
      roll(1, 6, 6, "w2");
      roll(1, 6, 6, "w3");
      roll(1, 6, 6, "w4");
      roll(1, 4, 4, "w5");
      rd_sel = 2'd1;
      #1;
      check("win_pre_score", rd_score, 28);
      check("win_pre_over", game_over, 0);
      roll(1, 8, 2, "w6");
      check("win_over", game_over, 1);
      check("win_winner", winner, 1);
      check("win_grant", grant, 0);
      check("win_throw", throw, 0);
      check("win_score", rd_score, 30);
      req = 4'b1111;
      tick();
      tick();
      check("over_grant", grant, 0);
      check("over_rolling", rolling, 0);
      check("over_hold", game_over, 1);

      // new_game leaves OVER but keeps winner; rst clears it
      new_game = 1'b1;
      req      = '0;
      tick();
      new_game = 1'b0;
      check("restart_over", game_over, 0);
      check("restart_winner", winner, 1);
      check("restart_score", rd_score, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_winner_clr", winner, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
